player_data_tx: RTL and testbench



---
 rtl/player_data_tx.sv | 148 ++++++++++++++
 tb/tb_player_data_tx.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/player_data_tx.sv
// player_data_tx: packs local player state into a 7-byte packet and streams
// it bytewise to the UART transmitter over a valid/ready handshake.
module player_data_tx #(
    parameter logic [7:0]  HEADER   = 8'hA5,
    parameter int unsigned TICK_DIV = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        frame_tick,
    input  logic [11:0] player_x,
    input  logic [11:0] player_y,
    input  logic        player_flip_h,
    input  logic [1:0]  player_class,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        overrun,
    output logic [15:0] packet_cnt
);

    typedef enum logic {IDLE, SEND} state_t;

    localparam logic [7:0] DIV_LAST = 8'(TICK_DIV - 1);
    localparam logic [2:0] LAST_IDX = 3'd6;

    state_t      state, state_d;
    logic [2:0]  idx, idx_d;
    logic [7:0]  div;
    logic        pending, pending_d;
    logic        overrun_d;
    logic [15:0] cnt_d;
    logic        load;
    logic        req;

    // Frozen copy of the player state for the packet in flight
    logic [11:0] snap_x, snap_y;
    logic        snap_flip;
    logic [1:0]  snap_class;

    logic [7:0]  b1, b2, b3, b4, b5, b6, cur;

    assign req = enable && frame_tick && (div == DIV_LAST);

    // Frame divider: only accepted ticks advance it, it holds while disabled
    always_ff @(posedge clk) begin
        if (rst)
            div <= 8'd0;
        else if (enable && frame_tick)
            div <= (div == DIV_LAST) ? 8'd0 : div + 8'd1;
    end

    // State register plus the snapshot taken whenever a packet (re)starts
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= 3'd0;
            pending    <= 1'b0;
            overrun    <= 1'b0;
            packet_cnt <= 16'd0;
            snap_x     <= 12'd0;
            snap_y     <= 12'd0;
            snap_flip  <= 1'b0;
            snap_class <= 2'd0;
        end else begin
            state      <= state_d;
            idx        <= idx_d;
            pending    <= pending_d;
            overrun    <= overrun_d;
            packet_cnt <= cnt_d;
            if (load) begin
                snap_x     <= player_x;
                snap_y     <= player_y;
                snap_flip  <= player_flip_h;
                snap_class <= player_class;
            end
        end
    end

    // Next-state: byte sequencing, back-to-back restart, pending/overrun
    always_comb begin
        state_d   = state;
        idx_d     = idx;
        pending_d = pending;
        overrun_d = 1'b0;
        cnt_d     = packet_cnt;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    load    = 1'b1;
                    idx_d   = 3'd0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (tx_ready && idx == LAST_IDX) begin
                    // Final byte leaves: count it and either chain or stop
                    cnt_d     = packet_cnt + 16'd1;
                    idx_d     = 3'd0;
                    pending_d = 1'b0;
                    if ((pending && enable) || req)
                        load = 1'b1;
                    else
                        state_d = IDLE;
                end else begin
                    if (tx_ready)
                        idx_d = idx + 3'd1;
                    if (!enable)
                        pending_d = 1'b0;
                    else if (req) begin
                        if (pending)
                            overrun_d = 1'b1;
                        else
                            pending_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Packet bytes derived from the frozen snapshot
    always_comb begin
        b1 = {4'h0, snap_x[11:8]};
        b2 = snap_x[7:0];
        b3 = {4'h0, snap_y[11:8]};
        b4 = snap_y[7:0];
        b5 = {5'b0, snap_class, snap_flip};
        b6 = b1 ^ b2 ^ b3 ^ b4 ^ b5;
        case (idx)
            3'd0:    cur = HEADER;
            3'd1:    cur = b1;
            3'd2:    cur = b2;
            3'd3:    cur = b3;
            3'd4:    cur = b4;
            3'd5:    cur = b5;
            default: cur = b6;
        endcase
    end

    // Outputs depend on registers only, never on tx_ready
    assign tx_valid = (state == SEND);
    assign busy     = (state == SEND);
    assign tx_data  = (state == SEND) ? cur : 8'h00;

endmodule

// File: tb/tb_player_data_tx.sv
// tb_player_data_tx: directed scenarios plus random traffic, all cycles
// compared against a queue-based packet model.
module tb_player_data_tx;

    localparam int TD = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1, enable = 1'b0, frame_tick = 1'b0, tx_ready = 1'b0;
    logic [11:0] px = 12'h0, py = 12'h0;
    logic        flip = 1'b0;
    logic [1:0]  pc = 2'd0;
    logic [7:0]  tx_data;
    logic        tx_valid, busy, overrun;
    logic [15:0] packet_cnt;

    always #5 clk = ~clk;

    player_data_tx #(.HEADER(8'hA5), .TICK_DIV(TD)) dut (
        .clk(clk), .rst(rst), .enable(enable), .frame_tick(frame_tick),
        .player_x(px), .player_y(py), .player_flip_h(flip), .player_class(pc),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .overrun(overrun), .packet_cnt(packet_cnt)
    );

    int errors = 0, checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: bytes still to send, divider, pending flag, counter
    logic [7:0]  m_q[$];
    logic [7:0]  log_q[$];
    int          m_div = 0;
    bit          m_busy = 0, m_pend = 0, m_ovr = 0;
    logic [15:0] m_cnt = 16'd0;
    int          ovr_seen = 0;
    bit          pat [12] = '{1,0,1,0,1,0,0,1,0,1,0,1};

    task automatic snap();
        logic [7:0] b [7];
        b[0] = 8'hA5;
        b[1] = {4'h0, px[11:8]};
        b[2] = px[7:0];
        b[3] = {4'h0, py[11:8]};
        b[4] = py[7:0];
        b[5] = {5'b0, pc, flip};
        b[6] = 8'h00;
        for (int i = 1; i < 6; i++) b[6] = b[6] ^ b[i];
        m_q.delete();
        for (int i = 0; i < 7; i++) m_q.push_back(b[i]);
    endtask

    task automatic cyc();
        bit req;
        if (tx_valid && tx_ready) log_q.push_back(tx_data);
        @(posedge clk);
        req = !rst && enable && frame_tick && (m_div == TD - 1);
        if (rst) begin
            m_div = 0; m_busy = 0; m_pend = 0; m_ovr = 0; m_cnt = 16'd0;
            m_q.delete();
        end else begin
            m_ovr = 0;
            if (!m_busy) begin
                if (req) begin snap(); m_busy = 1; end
            end else if (tx_ready && m_q.size() == 1) begin
                m_cnt = m_cnt + 16'd1;
                if ((m_pend && enable) || req) snap();
                else begin m_busy = 0; m_q.delete(); end
                m_pend = 0;
            end else begin
                if (tx_ready) void'(m_q.pop_front());
                if (!enable) m_pend = 0;
                else if (req) begin
                    if (m_pend) m_ovr = 1;
                    else m_pend = 1;
                end
            end
            if (enable && frame_tick) m_div = (m_div == TD - 1) ? 0 : m_div + 1;
        end
        #1;
        if (overrun) ovr_seen++;
        check("tx_valid", 32'(tx_valid), 32'(m_busy));
        check("busy", 32'(busy), 32'(m_busy));
        check("tx_data", 32'(tx_data), m_busy ? 32'(m_q[0]) : 32'h0);
        check("overrun", 32'(overrun), 32'(m_ovr));
        check("packet_cnt", 32'(packet_cnt), 32'(m_cnt));
    endtask

    task automatic drive(input bit t, input bit r);
        frame_tick = t;
        tx_ready   = r;
        cyc();
    endtask

    // Three accepted ticks = one send request with TICK_DIV=3
    task automatic fire(input bit r);
        drive(1, r); drive(0, r); drive(1, r); drive(0, r); drive(1, r);
        frame_tick = 0;
    endtask

    logic [7:0] exp_b [7] = '{8'hA5, 8'h01, 8'h23, 8'h02, 8'hAB, 8'h05, 8'h8E};
    int n;

    initial begin
        repeat (3) drive(0, 1);
        check("reset_cnt", 32'(packet_cnt), 32'h0);
        check("reset_data", 32'(tx_data), 32'h0);
        rst = 0; enable = 1;
        px = 12'h123; py = 12'h2AB; flip = 1; pc = 2'd2;

        // Basic packet
        log_q.delete();
        fire(1);
        repeat (12) drive(0, 1);
        check("basic_len", 32'(log_q.size()), 32'd7);
        for (int i = 0; i < 7; i++) check("basic_byte", 32'(log_q[i]), 32'(exp_b[i]));
        check("basic_cnt", 32'(packet_cnt), 32'd1);
        check("basic_busy", 32'(busy), 32'd0);

        // Backpressure on b3 with player_x changing mid-packet
        log_q.delete();
        fire(1);
        for (int i = 0; i < 20 && log_q.size() < 3; i++) drive(0, 1);
        check("bp_reach", 32'(log_q.size()), 32'd3);
        px = 12'hFFF;
        repeat (5) begin
            drive(0, 0);
            check("bp_hold_data", 32'(tx_data), 32'h02);
            check("bp_hold_valid", 32'(tx_valid), 32'd1);
        end
        repeat (10) drive(0, 1);
        check("bp_len", 32'(log_q.size()), 32'd7);
        for (int i = 0; i < 7; i++) check("bp_byte", 32'(log_q[i]), 32'(exp_b[i]));
        check("bp_cnt", 32'(packet_cnt), 32'd2);
        px = 12'h123;

        // Pending then overrun during a stalled packet, back-to-back release
        ovr_seen = 0;
        fire(0);
        repeat (2) repeat (3) begin drive(1, 0); drive(0, 0); end
        check("ovr_once", 32'(ovr_seen), 32'd1);
        log_q.delete();
        n = 0;
        for (int i = 0; i < 40; i++) begin
            drive(0, 1);
            n++;
            if (!tx_valid) break;
        end
        check("b2b_cycles", 32'(n), 32'd14);
        check("b2b_len", 32'(log_q.size()), 32'd14);
        check("b2b_cnt", 32'(packet_cnt), 32'd4);

        // Reset while b2 is presented
        log_q.delete();
        fire(1);
        for (int i = 0; i < 20 && log_q.size() < 2; i++) drive(0, 1);
        rst = 1;
        drive(0, 1);
        rst = 0;
        check("rst_valid", 32'(tx_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cnt", 32'(packet_cnt), 32'd0);
        log_q.delete();
        fire(1);
        repeat (10) drive(0, 1);
        check("rst_len", 32'(log_q.size()), 32'd7);
        check("rst_first", 32'(log_q[0]), 32'hA5);
        check("rst_cnt_after", 32'(packet_cnt), 32'd1);

        // Request coincident with the final-byte transfer
        ovr_seen = 0;
        log_q.delete();
        for (int i = 0; i < 12; i++) drive(pat[i], 1);
        frame_tick = 0;
        check("coinc_valid", 32'(tx_valid), 32'd1);
        check("coinc_data", 32'(tx_data), 32'hA5);
        check("coinc_len", 32'(log_q.size()), 32'd7);
        repeat (10) drive(0, 1);
        check("coinc_ovr", 32'(ovr_seen), 32'd0);
        check("coinc_cnt", 32'(packet_cnt), 32'd3);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rst    = ($urandom % 300) == 0;
            enable = ($urandom % 8) != 0;
            px     = 12'($urandom);
            py     = 12'($urandom);
            flip   = 1'($urandom);
            pc     = 2'($urandom);
            drive(($urandom % 3) == 0, 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
